fetch_pc: RTL and testbench

- Instruction-fetch front end directly upstream of the icache.
- Holds the architectural fetch PC and drives it combinationally onto the icache address input.
- Predicts taken branches/jumps with a small direct-mapped BTB using 2-bit counters.
- Registers the fetched PC and its prediction so they arrive at decode in the same cycle as the icache's registered instruction.

---
 rtl/fetch_pc.sv | 112 +++++++++++
 tb/tb_fetch_pc.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc.sv
// Fetch-stage PC generator: holds the fetch PC, predicts taken control flow with a
// direct-mapped BTB of 2-bit counters, and registers PC/prediction alongside the icache output.
package fetch_pc_pkg;
  typedef struct packed {
    logic stall;
    logic flush;
  } PipeControl;
endpackage

module fetch_pc
  import fetch_pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  PipeControl  pipe,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken,
  output logic [31:0] pc,
  output logic [31:0] pc_f,
  output logic        valid_f,
  output logic        pred_taken_f,
  output logic [31:0] pred_target_f
);
  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 30 - IDX;

  logic [BTB_ENTRIES-1:0] btb_valid;
  logic [TAG_W-1:0]       btb_tag    [BTB_ENTRIES];
  logic [29:0]            btb_target [BTB_ENTRIES];
  logic [1:0]             btb_ctr    [BTB_ENTRIES];

  logic [IDX-1:0]   look_idx, upd_idx;
  logic [TAG_W-1:0] look_tag, upd_tag;
  logic             look_hit, upd_hit, pred_taken;
  logic [31:0]      pred_target, pc_next;
  logic             unused_bits;

  assign look_idx = pc[IDX+1:2];
  assign look_tag = pc[31:IDX+2];
  assign upd_idx  = upd_pc[IDX+1:2];
  assign upd_tag  = upd_pc[31:IDX+2];

  // Lookup reads the array before this cycle's update lands, so same-index updates appear next cycle.
  assign look_hit    = btb_valid[look_idx] && (btb_tag[look_idx] == look_tag);
  assign pred_taken  = look_hit && btb_ctr[look_idx][1];
  assign pred_target = {btb_target[look_idx], 2'b00};
  assign upd_hit     = btb_valid[upd_idx] && (btb_tag[upd_idx] == upd_tag);

  // Byte-offset bits of the update addresses carry no information for the BTB.
  assign unused_bits = ^{upd_pc[1:0], upd_target[1:0]};

  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign a default first so no latch is inferred.
    pc_next = pc + 32'd4;
    if (redirect_valid)  pc_next = redirect_pc;
    else if (pipe.stall) pc_next = pc;
    else if (pred_taken) pc_next = pred_target;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' so all registers update from pre-edge values.
    if (rst) pc <= RESET_PC;
    else     pc <= pc_next;
  end

  // F register follows the icache output register rules: stall holds, flush bubbles.
  always_ff @(posedge clk) begin
    if (rst || (!pipe.stall && pipe.flush)) begin
      pc_f          <= '0;
      valid_f       <= 1'b0;
      pred_taken_f  <= 1'b0;
      pred_target_f <= '0;
    end else if (!pipe.stall) begin
      pc_f          <= pc;
      valid_f       <= 1'b1;
      pred_taken_f  <= pred_taken;
      pred_target_f <= pred_taken ? pred_target : 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      btb_valid <= '0;
    else if (upd_valid && !upd_hit && upd_taken)
      btb_valid[upd_idx] <= 1'b1;
  end

  // NOTE: only valid bits are reset; tag/target/ctr are don't-care until their entry is allocated.
  always_ff @(posedge clk) begin
    if (!rst && upd_valid) begin
      if (upd_hit) begin
        if (upd_taken) begin
          btb_ctr[upd_idx]    <= (btb_ctr[upd_idx] == 2'b11) ? 2'b11 : btb_ctr[upd_idx] + 2'b01;
          btb_target[upd_idx] <= upd_target[31:2];
        end else begin
          btb_ctr[upd_idx]    <= (btb_ctr[upd_idx] == 2'b00) ? 2'b00 : btb_ctr[upd_idx] - 2'b01;
        end
      end else if (upd_taken) begin
        btb_tag[upd_idx]    <= upd_tag;
        btb_target[upd_idx] <= upd_target[31:2];
        btb_ctr[upd_idx]    <= 2'b10;
      end
    end
  end
endmodule

// File: tb/tb_fetch_pc.sv
// Directed bench for fetch_pc: reset sequencing, stall/flush/redirect priority,
// BTB training, counter hysteresis, aliasing and same-cycle update/lookup ordering.
module tb_fetch_pc;
  import fetch_pc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  PipeControl  pipe;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic [31:0] pc, pc_f, pred_target_f;
  logic        valid_f, pred_taken_f;

  int checks = 0;
  int errors = 0;

  fetch_pc #(.RESET_PC(32'h0000_0100), .BTB_ENTRIES(16)) dut (
    .clk(clk), .rst(rst), .pipe(pipe),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
    .pc(pc), .pc_f(pc_f), .valid_f(valid_f),
    .pred_taken_f(pred_taken_f), .pred_target_f(pred_target_f)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Stimulus helpers: inputs change only at negedge, one posedge per call.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_redirect(input logic [31:0] addr);
    redirect_valid = 1'b1; redirect_pc = addr; pipe.flush = 1'b1;
    step();
    redirect_valid = 1'b0; pipe.flush = 1'b0;
  endtask

  task automatic do_update(input logic [31:0] a, input logic [31:0] t, input logic tk);
    upd_valid = 1'b1; upd_pc = a; upd_target = t; upd_taken = tk;
    step();
    upd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; pipe = '0; redirect_valid = 1'b0; redirect_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_target = '0; upd_taken = 1'b0;
    step(); step();
    rst = 1'b0;
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h100); end
    checks++; if ({valid_f, pred_taken_f} !== 2'b00 || pc_f !== 0 || pred_target_f !== 0) begin
      errors++; $display("FAIL reset_f: got v=%b p=%b pc_f=%h t=%h expected zeros", valid_f, pred_taken_f, pc_f, pred_target_f);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [2];
    exp_pc[0] = 32'h104; exp_pc[1] = 32'h108;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (pc !== exp_pc[i] || pc_f !== exp_pc[i] - 32'd4 || valid_f !== 1'b1) begin
        errors++; $display("FAIL seq%0d: got pc=%h pc_f=%h v=%b expected pc=%h pc_f=%h v=1",
                            i, pc, pc_f, valid_f, exp_pc[i], exp_pc[i] - 32'd4);
      end
    end
  endtask

  task automatic test_stall();
    pipe.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (pc !== 32'h108 || pc_f !== 32'h104 || valid_f !== 1'b1) begin
        errors++; $display("FAIL stall%0d: got pc=%h pc_f=%h v=%b expected pc=108 pc_f=104 v=1", i, pc, pc_f, valid_f);
      end
    end
    pipe.stall = 1'b0;
    step();
    checks++; if (pc !== 32'h10C || pc_f !== 32'h108) begin
      errors++; $display("FAIL stall_resume: got pc=%h pc_f=%h expected pc=10c pc_f=108", pc, pc_f);
    end
  endtask

  task automatic test_redirect_stall();
    redirect_valid = 1'b1; redirect_pc = 32'h200; pipe.stall = 1'b1; pipe.flush = 1'b1;
    step();
    redirect_valid = 1'b0; pipe.stall = 1'b0; pipe.flush = 1'b0;
    checks++; if (pc !== 32'h200 || pc_f !== 32'h108 || valid_f !== 1'b1) begin
      errors++; $display("FAIL redirect_stall: got pc=%h pc_f=%h v=%b expected pc=200 pc_f=108 v=1", pc, pc_f, valid_f);
    end
    step();
    checks++; if (pc !== 32'h204 || pc_f !== 32'h200 || valid_f !== 1'b1) begin
      errors++; $display("FAIL redirect_after: got pc=%h pc_f=%h v=%b expected pc=204 pc_f=200 v=1", pc, pc_f, valid_f);
    end
  endtask

  task automatic test_flush_wrap_misaligned();
    pipe.flush = 1'b1;
    step();
    pipe.flush = 1'b0;
    checks++; if (pc !== 32'h208 || valid_f !== 1'b0 || pc_f !== 0) begin
      errors++; $display("FAIL flush_only: got pc=%h pc_f=%h v=%b expected pc=208 pc_f=0 v=0", pc, pc_f, valid_f);
    end
    do_redirect(32'hFFFF_FFFC);
    step();
    checks++; if (pc !== 32'h0 || pc_f !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap: got pc=%h pc_f=%h expected pc=0 pc_f=fffffffc", pc, pc_f);
    end
    do_redirect(32'h203);
    checks++; if (pc !== 32'h203) begin errors++; $display("FAIL misaligned: got %h expected %h", pc, 32'h203); end
  endtask

  // Visit addr via redirect and check the next pc and the F-stage prediction for addr.
  task automatic visit(input string name, input logic [31:0] addr, input logic [31:0] exp_next,
                       input logic exp_pt, input logic [31:0] exp_pt_target);
    do_redirect(addr);
    step();
    checks++; if (pc !== exp_next || pc_f !== addr || pred_taken_f !== exp_pt || pred_target_f !== exp_pt_target) begin
      errors++; $display("FAIL %s: got pc=%h pc_f=%h pt=%b tgt=%h expected pc=%h pc_f=%h pt=%b tgt=%h",
                          name, pc, pc_f, pred_taken_f, pred_target_f, exp_next, addr, exp_pt, exp_pt_target);
    end
  endtask

  task automatic test_train();
    visit("cold_120", 32'h120, 32'h124, 1'b0, 32'h0);
    do_update(32'h120, 32'h180, 1'b1);
    visit("trained_120", 32'h120, 32'h180, 1'b1, 32'h180);
    step();
    checks++; if (pc_f !== 32'h180 || pred_taken_f !== 1'b0 || pred_target_f !== 0) begin
      errors++; $display("FAIL target_fetch: got pc_f=%h pt=%b tgt=%h expected pc_f=180 pt=0 tgt=0", pc_f, pred_taken_f, pred_target_f);
    end
  endtask

  task automatic test_hysteresis();
    do_update(32'h120, 32'h180, 1'b0);
    do_update(32'h120, 32'h180, 1'b0);
    visit("ctr00", 32'h120, 32'h124, 1'b0, 32'h0);
    do_update(32'h120, 32'h180, 1'b1);
    visit("ctr01", 32'h120, 32'h124, 1'b0, 32'h0);
    do_update(32'h120, 32'h180, 1'b1);
    visit("ctr10", 32'h120, 32'h180, 1'b1, 32'h180);
  endtask

  task automatic test_alias();
    visit("alias_lookup", 32'h160, 32'h164, 1'b0, 32'h0);
    do_update(32'h160, 32'h300, 1'b0);
    visit("alias_nt_keeps", 32'h120, 32'h180, 1'b1, 32'h180);
    do_update(32'h160, 32'h300, 1'b1);
    visit("alias_evicted", 32'h120, 32'h124, 1'b0, 32'h0);
    visit("alias_new", 32'h160, 32'h300, 1'b1, 32'h300);
  endtask

  task automatic test_back_to_back();
    // Update lands on the same index as the live lookup: prediction uses the old ctr (10).
    do_redirect(32'h160);
    upd_valid = 1'b1; upd_pc = 32'h160; upd_target = 32'h300; upd_taken = 1'b0;
    step();
    upd_valid = 1'b0;
    checks++; if (pc !== 32'h300) begin errors++; $display("FAIL same_cycle: got %h expected %h", pc, 32'h300); end
    visit("after_same_cycle", 32'h160, 32'h164, 1'b0, 32'h0);
  endtask

  task automatic test_reset_discard();
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h500;
    upd_valid = 1'b1; upd_pc = 32'h120; upd_target = 32'h700; upd_taken = 1'b1;
    step();
    rst = 1'b0; redirect_valid = 1'b0; upd_valid = 1'b0;
    checks++; if (pc !== 32'h100 || valid_f !== 1'b0) begin
      errors++; $display("FAIL reset_discard: got pc=%h v=%b expected pc=100 v=0", pc, valid_f);
    end
    visit("btb_cleared", 32'h120, 32'h124, 1'b0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_stall();
    test_flush_wrap_misaligned();
    test_train();
    test_hysteresis();
    test_alias();
    test_back_to_back();
    test_reset_discard();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
